// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller for a time-multiplexed common-anode 7-segment bank with dead-time between digits.
// Latency: all outputs registered; display value changes only at frame boundaries (wrap or enable rise).
// No backpressure: free-running scan. Optional SEVENSEG_LZ_SUPPRESS_EN blanks leading-zero digits.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int ON_CYCLES   = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int MAXC = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LAST = (DEAD_CYCLES > 0) ? CW'(DEAD_CYCLES - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    en_q;
    logic [3:0]              code_q, code_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    done_q;
    logic                    wrap;
    logic                    frame_bnd;
    logic                    digit_blank;

    // Scan sequencing: dead slot then on slot per digit; disable parks at digit 0 dark.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        if (!enable) begin
            state_d = ST_DEAD;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_DEAD: begin
                    if (DEAD_CYCLES == 0 || cnt_q == DEAD_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_ON: begin
                    if (cnt_q == ON_LAST) begin
                        cnt_d   = '0;
                        state_d = (DEAD_CYCLES == 0) ? ST_ON : ST_DEAD;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Double buffer: a load on a boundary edge bypasses straight to the displayed copy.
    always_comb begin
        frame_bnd = enable && (!en_q || wrap);
        pending_d = load ? value : pending_q;
        shadow_d  = frame_bnd ? pending_d : shadow_q;
    end

`ifdef SEVENSEG_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  upper_zero;

    // Digit i>0 is blank when it and every more-significant nibble are zero.
    always_comb begin
        blank_vec  = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero   = upper_zero && (shadow_d[4*i +: 4] == 4'h0);
            blank_vec[i] = upper_zero;
        end
        digit_blank = blank_vec[idx_d];
    end
`else
    assign digit_blank = 1'b0;
`endif

    // Output decode from next state so registered outputs line up with the state they describe.
    always_comb begin
        code_d = shadow_d[4*idx_d +: 4];
        sel_d  = '1;
        if (state_d == ST_ON && !digit_blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (IW'(i) == idx_d) begin
                    sel_d[i] = 1'b0;
                end
            end
        end
    end

    // State, buffers and registered outputs; reset overrides enable and load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_DEAD;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            shadow_q  <= '0;
            en_q      <= 1'b0;
            code_q    <= 4'h0;
            sel_q     <= '1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            en_q      <= enable;
            code_q    <= code_d;
            sel_q     <= sel_d;
            done_q    <= wrap;
        end
    end

    assign digit_code = code_q;
    assign digit_sel  = sel_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with NUM_DIGITS=4, ON_CYCLES=4, DEAD_CYCLES=1.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Frame of 20 cycles: per digit 1 dark cycle followed by 4 lit cycles.
module tb_sevenseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  digit_code;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS (4),
        .ON_CYCLES  (4),
        .DEAD_CYCLES(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .value     (value),
        .digit_code(digit_code),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame(input string tag);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_done === 1'b1) break;
        end
        check(tag, {31'b0, frame_done}, 32'd1);
    endtask

    // Runs one frame starting from the dark cycle before digit 0.
    // ld_pos 1: load during digit 1's first lit cycle; 2: load on the closing boundary edge.
    task automatic run_frame(input string tag, input logic [15:0] cur, input logic [3:0] next0,
                             input logic [3:0] lit, input int ld_pos, input logic [15:0] ld_val);
        logic [3:0] exp_sel;
        logic [3:0] exp_code;
        logic [3:0] one;
        one = 4'b0001;
        for (int d = 0; d < 4; d++) begin
            exp_sel  = lit[d] ? ~(one << d) : 4'b1111;
            exp_code = cur[4*d +: 4];
            for (int k = 0; k < 4; k++) begin
                tick();
                load = 1'b0;
                check($sformatf("%s_d%0d_k%0d_sel", tag, d, k), {28'b0, digit_sel}, {28'b0, exp_sel});
                check($sformatf("%s_d%0d_k%0d_code", tag, d, k), {28'b0, digit_code}, {28'b0, exp_code});
                check($sformatf("%s_d%0d_k%0d_fd", tag, d, k), {31'b0, frame_done}, 32'd0);
                if ((ld_pos == 1 && d == 1 && k == 0) || (ld_pos == 2 && d == 3 && k == 3)) begin
                    load  = 1'b1;
                    value = ld_val;
                end
            end
            tick();
            load = 1'b0;
            exp_code = (d == 3) ? next0 : cur[4*(d+1) +: 4];
            check($sformatf("%s_dead%0d_sel", tag, d), {28'b0, digit_sel}, 32'hF);
            check($sformatf("%s_dead%0d_code", tag, d), {28'b0, digit_code}, {28'b0, exp_code});
            check($sformatf("%s_dead%0d_fd", tag, d), {31'b0, frame_done}, (d == 3) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [3:0] lit_a;
        logic [3:0] lit_b;
`ifdef SEVENSEG_LZ_SUPPRESS_EN
        lit_a = 4'b0011;
        lit_b = 4'b0001;
`else
        lit_a = 4'b1111;
        lit_b = 4'b1111;
`endif
        // Reset held for two edges with enable high.
        tick();
        tick();
        check("rst_sel", {28'b0, digit_sel}, 32'hF);
        check("rst_code", {28'b0, digit_code}, 32'h0);
        check("rst_fd", {31'b0, frame_done}, 32'd0);
        reset = 1'b0;
        tick();
        check("first_on_sel", {28'b0, digit_sel}, 32'hE);
        check("first_on_code", {28'b0, digit_code}, 32'h0);

        // Steady scan of 1234.
        load  = 1'b1;
        value = 16'h1234;
        tick();
        load = 1'b0;
        wait_frame("wait_1234");
        check("bnd_1234_sel", {28'b0, digit_sel}, 32'hF);
        check("bnd_1234_code", {28'b0, digit_code}, 32'h4);
        run_frame("scan", 16'h1234, 4'h4, 4'b1111, 0, 16'h0);

        // Mid-frame load must not tear the current frame.
        run_frame("tear", 16'h1234, 4'hD, 4'b1111, 1, 16'hABCD);
        run_frame("abcd", 16'hABCD, 4'hD, 4'b1111, 0, 16'h0);

        // Load on the boundary edge shows in the immediately following frame.
        run_frame("coin", 16'hABCD, 4'h8, 4'b1111, 2, 16'h5678);
        run_frame("s5678", 16'h5678, 4'h8, 4'b1111, 0, 16'h0);

        // Drop enable during digit 2's lit slot.
        for (int i = 0; i < 11; i++) tick();
        check("pre_dis_sel", {28'b0, digit_sel}, 32'hB);
        check("pre_dis_code", {28'b0, digit_code}, 32'h6);
        enable = 1'b0;
        load   = 1'b1;
        value  = 16'h4321;
        tick();
        load = 1'b0;
        check("dis_sel", {28'b0, digit_sel}, 32'hF);
        check("dis_code", {28'b0, digit_code}, 32'h8);
        check("dis_fd", {31'b0, frame_done}, 32'd0);
        tick();
        check("dis2_sel", {28'b0, digit_sel}, 32'hF);
        enable = 1'b1;
        tick();
        check("reen_sel", {28'b0, digit_sel}, 32'hE);
        check("reen_code", {28'b0, digit_code}, 32'h1);
        for (int i = 0; i < 4; i++) tick();
        check("reen_dead1_sel", {28'b0, digit_sel}, 32'hF);
        check("reen_dead1_code", {28'b0, digit_code}, 32'h2);

        // Reset mid-operation clears both buffers.
        reset = 1'b1;
        tick();
        check("mrst_sel", {28'b0, digit_sel}, 32'hF);
        check("mrst_code", {28'b0, digit_code}, 32'h0);
        check("mrst_fd", {31'b0, frame_done}, 32'd0);
        reset = 1'b0;
        tick();
        check("mrst_on_sel", {28'b0, digit_sel}, 32'hE);
        check("mrst_on_code", {28'b0, digit_code}, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        check("mrst_on1_sel", {28'b0, digit_sel}, 32'hD);
        check("mrst_on1_code", {28'b0, digit_code}, 32'h0);

        // Leading-zero handling: 0050 then 0000.
        load  = 1'b1;
        value = 16'h0050;
        tick();
        load = 1'b0;
        wait_frame("wait_0050");
        check("bnd_0050_code", {28'b0, digit_code}, 32'h0);
        run_frame("lz50", 16'h0050, 4'h0, lit_a, 1, 16'h0000);
        run_frame("lz00", 16'h0000, 4'h0, lit_b, 0, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It shares one 4-bit-to-7-segment active-low decoder across NUM_DIGITS digits. Each cycle it presents one nibble (digit_code) to the decoder and asserts the matching active-low digit enable, with a dead-time gap between digits against ghosting. The display value is double-buffered and updated only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1-8); digit 0 is least significant.
ON_CYCLES, 50000, clock cycles each digit is driven (>=1).
DEAD_CYCLES, 500, clock cycles with all digits off before each digit (>=0; 0 means no gap).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  scan enable; low forces display dark and restarts the scan.
load  input  1  one-cycle strobe that captures value.
value  input  4*NUM_DIGITS  nibble i = value[4i+3:4i] is shown on digit i.
digit_code  output  4  nibble sent to the external decoder.
digit_sel  output  NUM_DIGITS  active-low digit enables; at most one bit low at a time.
frame_done  output  1  one-cycle pulse when the last digit's ON slot ends.

Behaviour:
- All outputs registered. Reset (synchronous, active-high): digit_sel all 1, digit_code 0, frame_done 0, idx 0, cycle counter 0, pending and shadow 0, state DEAD.
- Registers: pending (written on load), shadow (drives display), idx (current digit), cnt (cycle counter).
- FSM states:
  - DEAD: digit_sel all 1; digit_code = shadow nibble[idx]; lasts DEAD_CYCLES cycles, then goes to ON with cnt cleared. If DEAD_CYCLES=0, DEAD is skipped and ON follows ON directly.
  - ON: digit_sel[idx]=0, all other bits 1; digit_code = shadow nibble[idx]; lasts ON_CYCLES cycles.
  - At the end of ON: idx advances; NUM_DIGITS-1 wraps to 0. On the wrap, frame_done=1 for exactly one cycle.
- Frame period is NUM_DIGITS*(DEAD_CYCLES+ON_CYCLES) cycles.
- Frame boundary: the cycle in which idx wraps to 0, or the first cycle after enable rises. At a frame boundary, shadow<=pending.
- load: pending<=value on the clock edge where load=1.
  - If load coincides with a frame boundary, value bypasses pending and goes straight to shadow (pending also updated).
  - A load mid-frame is not visible until the next frame.
  - Multiple loads in one frame: the last one wins.
- enable=0: the next edge forces state DEAD, idx 0, cnt 0, digit_sel all 1, frame_done 0. digit_code follows shadow nibble 0. load still captures into pending.
- enable rise: the scan restarts at digit 0 with a DEAD slot; shadow<=pending (or value, if load is high that cycle).
- reset has priority over enable and load; reset mid-frame returns to the reset state on the next edge.
- cnt width is clog2(max(ON_CYCLES,DEAD_CYCLES)); cnt must never overflow.

Optional Feature:
Macro SEVENSEG_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression. Digit i is blanked if shadow nibbles i..NUM_DIGITS-1 are all 0 and i>0.
  - A blanked digit keeps digit_sel all 1 during its ON slot.
  - digit_code, slot timing and frame_done are unchanged.
  - Digit 0 is never suppressed.
- Undefined: every digit is driven; no extra logic.

Test Plan:
(NUM_DIGITS=4, ON_CYCLES=4, DEAD_CYCLES=1)
1. Reset: assert reset 2 cycles with enable=1 -> digit_sel=4'b1111, digit_code=0, frame_done=0. After release, the first ON slot has digit_sel=4'b1110, code 0.
2. Steady scan: load 16'h1234, wait one frame boundary -> per digit, 1 cycle of 4'b1111 then 4 cycles of 1110/code4, 1101/code3, 1011/code2, 0111/code1. frame_done pulses every 20 cycles. Never two sel bits low.
3. Tearing guard: shadow=16'h1234; load 16'hABCD during digit 1's ON slot -> the rest of the frame shows 2,1. The next frame shows D,C,B,A.
4. Coincident load: load 16'h5678 in the exact frame-boundary cycle -> the immediately following frame shows 8,7,6,5.
5. Enable/reset mid-operation: drop enable during digit 2's ON slot -> next cycle digit_sel=4'b1111. Re-raise -> 1 DEAD cycle, then digit 0 ON. Repeat with reset instead -> outputs return to reset values and shadow becomes 0.
6. LZ: value 16'h0050 with SEVENSEG_LZ_SUPPRESS_EN defined -> digit 3 and digit 2 slots stay 4'b1111, digit 1 shows sel 1101/code 5, digit 0 shows sel 1110/code 0. With the macro undefined -> all four digits driven. value 16'h0000 with macro defined -> only digit 0 lit.
